// File: rtl/btn_debouncer_pkg.sv
// Shared constants for the push-button conditioning stage and the capture
// stage that consumes its pulses.
package btn_debouncer_pkg;

  // Counter width for a given debounce length; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

  // 10 ms of stability at a 100 MHz system clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_CNT_W           = cnt_width(DEFAULT_DEBOUNCE_CYCLES);

  // Button roles, shared with the operand/opcode capture stage.
  localparam int BTN_OPA    = 0;
  localparam int BTN_OPB    = 1;
  localparam int BTN_OPCODE = 2;
  localparam int BTN_CLEAR  = 3;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, stability counter, debounced level and
// a one-cycle pulse on each debounced rising edge.
module btn_debounce_ch
  import btn_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES, // >= 2
  parameter int SYNC_STAGES     = 2                        // >= 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_raw,
  output logic o_btn_level,
  output logic o_btn_pulse
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   q;
  logic                   q_next;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   p;
  logic                   p_next;

  // Shift the asynchronous button level through the synchroniser chain.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_btn_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Count consecutive cycles of disagreement; commit the new level on the
  // last one. Any agreement restarts the count, which rejects bounce trains.
  // The counter stops at CNT_LAST and clears on the commit, so it never wraps.
  always_comb begin
    q_next   = q;
    cnt_next = '0;
    p_next   = 1'b0;
    if (s != q) begin
      if (cnt == CNT_LAST) begin
        q_next = s;
        p_next = s;  // pulse only when the debounced level rises
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  // Debounce state registers; reset mid-count abandons the pending change.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      q   <= 1'b0;
      cnt <= '0;
      p   <= 1'b0;
    end else begin
      q   <= q_next;
      cnt <= cnt_next;
      p   <= p_next;
    end
  end

  assign o_btn_level = q;
  assign o_btn_pulse = p;

endmodule

// File: rtl/btn_debouncer.sv
// Push-button conditioning: NUM_BTNS independent debounced channels, each
// producing a registered level and a single-cycle press pulse.
module btn_debouncer
  import btn_debouncer_pkg::*;
#(
  parameter int NUM_BTNS        = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES, // >= 2
  parameter int SYNC_STAGES     = 2                        // >= 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NUM_BTNS-1:0] i_btn_raw,
  output logic [NUM_BTNS-1:0] o_btn_level,
  output logic [NUM_BTNS-1:0] o_btn_pulse
);

  // Channels never interact; simultaneous presses give coincident pulses
  // and the downstream capture stage decides priority.
  for (genvar n = 0; n < NUM_BTNS; n++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_btn_raw   (i_btn_raw[n]),
      .o_btn_level (o_btn_level[n]),
      .o_btn_pulse (o_btn_pulse[n])
    );
  end

endmodule
